// File: rtl/pkg_mux.sv
// Shared definitions for the parametrised scan multiplexer: mode encodings,
// controller state type and a constant-evaluable ceil(log2) helper.
package pkg_mux;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // ceil(log2(n)); callers guarantee n >= 2
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_ctr.sv
// Scan sequencer: channel pointer plus dwell down-counter. Exposes the
// post-edge pointer and wrap flag so the output stage registers them in step.
module scan_ctr #(
    parameter int NCH     = 32,
    parameter int DWELL_W = 4,
    parameter int SW      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell_in,
    output logic [SW-1:0]      ptr_next,
    output logic               wrap_next
);

    localparam logic [SW-1:0] LAST = SW'(NCH - 1);

    logic [SW-1:0]      ptr_reg;
    logic [DWELL_W-1:0] cnt_reg;
    logic [DWELL_W-1:0] cnt_next;

    always_comb begin
        ptr_next  = ptr_reg;
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        if (load) begin
            ptr_next = '0;
            cnt_next = dwell_in;
        end else if (step) begin
            // dwell is only sampled here, so mid-slot changes wait for the next channel
            if (cnt_reg == '0) begin
                cnt_next = dwell_in;
                if (ptr_reg == LAST) begin
                    ptr_next  = '0;
                    wrap_next = 1'b1;
                end else begin
                    ptr_next = ptr_reg + SW'(1);
                end
            end else begin
                cnt_next = cnt_reg - DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/param_scan_mux.sv
// Registered NCH:1 multiplexer of W-bit lanes with manual select or an
// auto-scan sequencer; every sample carries its channel index and a valid flag.
module param_scan_mux
    import pkg_mux::*;
#(
    parameter int  NCH     = 32,
    parameter int  W       = 1,
    parameter int  DWELL_W = 4,
    localparam int SW      = clog2(NCH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NCH*W-1:0]   X,
    input  logic [SW-1:0]      XS,
    input  logic               XEN,
    input  logic               MODE,
    input  logic [DWELL_W-1:0] DWELL,
    output logic [W-1:0]       XOUT,
    output logic [SW-1:0]      XCH,
    output logic               XVALID,
    output logic               WRAP
);

    localparam int             NSLOT = 1 << SW;
    localparam logic [SW:0]    NCH_V = (SW + 1)'(NCH);

    state_t        state_reg;
    state_t        state_next;
    logic [W-1:0]  ch [NSLOT];
    logic [W-1:0]  xout_reg;
    logic [W-1:0]  xout_next;
    logic [SW-1:0] xch_reg;
    logic [SW-1:0] xch_next;
    logic          xvalid_reg;
    logic          xvalid_next;
    logic          wrap_reg;
    logic          wrap_next;
    logic          scan_load;
    logic          scan_step;
    logic [SW-1:0] ptr_next;
    logic          ctr_wrap;
    logic          sel_ok;

    // Unused select codes above NCH-1 read a constant zero lane
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_ch
            if (gi < NCH) begin : g_live
                assign ch[gi] = X[gi*W +: W];
            end else begin : g_pad
                assign ch[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (XEN) begin
            state_next = (MODE == MODE_SCAN) ? SCAN : MANUAL;
        end
    end

    // Any entry into SCAN restarts at channel 0; there is no resume
    assign scan_load = (state_next == SCAN) && (state_reg != SCAN);
    assign scan_step = (state_next == SCAN) && (state_reg == SCAN);
    assign sel_ok    = {1'b0, XS} < NCH_V;

    scan_ctr #(
        .NCH     (NCH),
        .DWELL_W (DWELL_W),
        .SW      (SW)
    ) u_scan_ctr (
        .clk       (CLK),
        .rst       (RST),
        .load      (scan_load),
        .step      (scan_step),
        .dwell_in  (DWELL),
        .ptr_next  (ptr_next),
        .wrap_next (ctr_wrap)
    );

    always_comb begin
        xout_next   = '0;
        xch_next    = '0;
        xvalid_next = 1'b0;
        wrap_next   = 1'b0;
        case (state_next)
            MANUAL: begin
                xout_next   = ch[XS];
                xch_next    = XS;
                xvalid_next = sel_ok;
            end
            SCAN: begin
                xout_next   = ch[ptr_next];
                xch_next    = ptr_next;
                xvalid_next = 1'b1;
                wrap_next   = ctr_wrap;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xout_reg   <= '0;
            xch_reg    <= '0;
            xvalid_reg <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            xout_reg   <= xout_next;
            xch_reg    <= xch_next;
            xvalid_reg <= xvalid_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign XOUT   = xout_reg;
    assign XCH    = xch_reg;
    assign XVALID = xvalid_reg;
    assign WRAP   = wrap_reg;

endmodule

// File: tb/tb_param_scan_mux.sv
// Bench for param_scan_mux: three configurations (32x1, 8x8, 5x4) checked
// against a slot-based behavioural model with directed and random stimulus.
module tb_param_scan_mux;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // instance a: NCH=32 W=1
    logic [31:0] a_x = '0;
    logic [4:0]  a_xs = '0;
    logic        a_en = 1'b0, a_mode = 1'b0;
    logic [3:0]  a_dwell = '0;
    logic [0:0]  a_xout;
    logic [4:0]  a_xch;
    logic        a_xvalid, a_wrap;
    // instance b: NCH=8 W=8
    logic [63:0] b_x = '0;
    logic [2:0]  b_xs = '0;
    logic        b_en = 1'b0, b_mode = 1'b0;
    logic [3:0]  b_dwell = '0;
    logic [7:0]  b_xout;
    logic [2:0]  b_xch;
    logic        b_xvalid, b_wrap;
    // instance c: NCH=5 W=4
    logic [19:0] c_x = '0;
    logic [2:0]  c_xs = '0;
    logic        c_en = 1'b0, c_mode = 1'b0;
    logic [3:0]  c_dwell = '0;
    logic [3:0]  c_xout;
    logic [2:0]  c_xch;
    logic        c_xvalid, c_wrap;

    param_scan_mux #(.NCH(32), .W(1), .DWELL_W(4)) u_a (
        .CLK(CLK), .RST(RST), .X(a_x), .XS(a_xs), .XEN(a_en), .MODE(a_mode), .DWELL(a_dwell),
        .XOUT(a_xout), .XCH(a_xch), .XVALID(a_xvalid), .WRAP(a_wrap));
    param_scan_mux #(.NCH(8), .W(8), .DWELL_W(4)) u_b (
        .CLK(CLK), .RST(RST), .X(b_x), .XS(b_xs), .XEN(b_en), .MODE(b_mode), .DWELL(b_dwell),
        .XOUT(b_xout), .XCH(b_xch), .XVALID(b_xvalid), .WRAP(b_wrap));
    param_scan_mux #(.NCH(5), .W(4), .DWELL_W(4)) u_c (
        .CLK(CLK), .RST(RST), .X(c_x), .XS(c_xs), .XEN(c_en), .MODE(c_mode), .DWELL(c_dwell),
        .XOUT(c_xout), .XCH(c_xch), .XVALID(c_xvalid), .WRAP(c_wrap));

    wire [7:0]  act_a = {a_xout, a_xch, a_xvalid, a_wrap};
    wire [12:0] act_b = {b_xout, b_xch, b_xvalid, b_wrap};
    wire [8:0]  act_c = {c_xout, c_xch, c_xvalid, c_wrap};

    // Model: a scan presents the current channel for len cycles (len = DWELL+1
    // sampled when that channel's slot began); age counts cycles shown so far.
    typedef struct packed {
        bit         scan;
        int         ch;
        int         age;
        int         len;
        logic [7:0] out;
        int         xch;
        bit         valid;
        bit         wrap;
    } mdl_t;

    mdl_t ma = '0, mb = '0, mc = '0;
    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [7:0] chan(logic [63:0] x, int k, int w);
        logic [63:0] v;
        v = x >> (k * w);
        return v[7:0] & 8'((1 << w) - 1);
    endfunction

    function automatic mdl_t step(mdl_t m, int nch, int w, bit en, bit mode,
                                  int xs, int dwell, logic [63:0] x);
        mdl_t r = m;
        if (!en) begin
            r = '0;
        end else if (!mode) begin
            r.scan  = 0;
            r.xch   = xs;
            r.valid = (xs < nch);
            r.out   = (xs < nch) ? chan(x, xs, w) : 8'h00;
            r.wrap  = 0;
        end else begin
            if (!m.scan) begin
                r.scan = 1; r.ch = 0; r.age = 1; r.len = dwell + 1; r.wrap = 0;
            end else if (m.age == m.len) begin
                r.ch   = (m.ch + 1) % nch;
                r.age  = 1;
                r.len  = dwell + 1;
                r.wrap = (r.ch == 0);
            end else begin
                r.age  = m.age + 1;
                r.wrap = 0;
            end
            r.xch   = r.ch;
            r.valid = 1;
            r.out   = chan(x, r.ch, w);
        end
        return r;
    endfunction

    function automatic logic [7:0]  exp_a(); return {ma.out[0],   5'(ma.xch), ma.valid, ma.wrap}; endfunction
    function automatic logic [12:0] exp_b(); return {mb.out,      3'(mb.xch), mb.valid, mb.wrap}; endfunction
    function automatic logic [8:0]  exp_c(); return {mc.out[3:0], 3'(mc.xch), mc.valid, mc.wrap}; endfunction

    // One clock: models absorb the inputs seen at the edge; returns on the falling edge
    task automatic tick();
        @(posedge CLK);
        ma = step(ma, 32, 1, a_en, a_mode, int'(a_xs), int'(a_dwell), 64'(a_x));
        mb = step(mb, 8, 8, b_en, b_mode, int'(b_xs), int'(b_dwell), b_x);
        mc = step(mc, 5, 4, c_en, c_mode, int'(c_xs), int'(c_dwell), 64'(c_x));
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_checks++;
        if ({act_a, act_b, act_c} !== '0)
            $display("FAIL reset_init: a=%h b=%h c=%h expected all zero", act_a, act_b, act_c);
        else n_pass++;
        RST = 1'b0;
        a_en = 1; a_mode = 0; a_xs = 0; a_x = 32'h1;
        b_en = 1; b_mode = 1; b_dwell = 1; b_x = 64'hFF;
        tick();
        n_checks++;
        if (act_a !== exp_a() || act_b !== exp_b())
            $display("FAIL reset_prerun: a=%h b=%h expected a=%h b=%h", act_a, act_b, exp_a(), exp_b());
        else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({act_a, act_b, act_c} !== '0)
            $display("FAIL reset_async: a=%h b=%h c=%h expected all zero", act_a, act_b, act_c);
        else n_pass++;
        ma = '0; mb = '0; mc = '0;
        @(negedge CLK);
        a_en = 0; b_en = 0; c_en = 0;
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (a_xvalid !== 1'b0 || a_xout !== 1'b0 || act_b !== exp_b())
                $display("FAIL reset_release cyc %0d: a=%h b=%h expected a=00 b=%h", i, act_a, act_b, exp_b());
            else n_pass++;
        end
    endtask

    task automatic test_manual_32();
        int xs_t[3]  = '{0, 31, 5};
        int out_t[3] = '{1, 1, 0};
        a_x = 32'h8000_0001; a_en = 1; a_mode = 0;
        for (int i = 0; i < 3; i++) begin
            a_xs = 5'(xs_t[i]);
            tick();
            n_checks++;
            if (a_xout !== 1'(out_t[i]) || a_xch !== 5'(xs_t[i]) || a_xvalid !== 1'b1 || a_wrap !== 1'b0)
                $display("FAIL manual32 xs=%0d: xout=%0d xch=%0d valid=%0d expected xout=%0d xch=%0d valid=1",
                         xs_t[i], a_xout, a_xch, a_xvalid, out_t[i], xs_t[i]);
            else n_pass++;
        end
    endtask

    task automatic test_manual_8();
        for (int k = 0; k < 8; k++) b_x[k*8 +: 8] = 8'hA0 + 8'(k);
        b_en = 1; b_mode = 0; b_xs = 3;
        tick();
        n_checks++;
        if (b_xout !== 8'hA3 || b_xch !== 3'd3 || b_xvalid !== 1'b1)
            $display("FAIL manual8: xout=%h xch=%0d valid=%0d expected a3 3 1", b_xout, b_xch, b_xvalid);
        else n_pass++;
        b_en = 0;
        tick();
        n_checks++;
        if (act_b !== 13'h0)
            $display("FAIL manual8_disable: got %h expected 0000", act_b);
        else n_pass++;
    endtask

    task automatic test_scan_8();
        int xch_t[5] = '{0, 0, 1, 2, 3};
        b_en = 1; b_mode = 1; b_dwell = 2;
        for (int i = 0; i < 30; i++) begin
            if (i == 25) b_dwell = 0;
            b_x = {$urandom, $urandom};
            tick();
            n_checks++;
            if (i < 25 && (b_xch !== 3'((i / 3) % 8) || b_wrap !== (i == 24)))
                $display("FAIL scan8_seq cyc %0d: xch=%0d wrap=%0d expected xch=%0d wrap=%0d",
                         i, b_xch, b_wrap, (i / 3) % 8, (i == 24));
            else if (i >= 25 && (b_xch !== 3'(xch_t[i-25]) || b_wrap !== 1'b0))
                $display("FAIL scan8_dwell_change cyc %0d: xch=%0d wrap=%0d expected xch=%0d wrap=0",
                         i, b_xch, b_wrap, xch_t[i-25]);
            else n_pass++;
            n_checks++;
            if (act_b !== exp_b())
                $display("FAIL scan8_model cyc %0d: got %h expected %h", i, act_b, exp_b());
            else n_pass++;
        end
    endtask

    task automatic test_scan_32();
        a_en = 1; a_mode = 1; a_dwell = 0; a_xs = 7;
        for (int i = 0; i < 70; i++) begin
            a_x = $urandom;
            tick();
            n_checks++;
            if (a_xch !== 5'(i % 32) || a_wrap !== (i > 0 && i % 32 == 0) || a_xout !== a_x[i % 32])
                $display("FAIL scan32 cyc %0d: xch=%0d wrap=%0d xout=%0d expected xch=%0d wrap=%0d xout=%0d",
                         i, a_xch, a_wrap, a_xout, i % 32, (i > 0 && i % 32 == 0), a_x[i % 32]);
            else n_pass++;
        end
        a_mode = 0;
        tick();
        n_checks++;
        if (a_xch !== 5'd7 || a_xvalid !== 1'b1 || a_wrap !== 1'b0)
            $display("FAIL scan32_to_manual: xch=%0d valid=%0d wrap=%0d expected 7 1 0", a_xch, a_xvalid, a_wrap);
        else n_pass++;
        a_mode = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (a_xch !== 5'(i) || a_wrap !== 1'b0 || act_a !== exp_a())
                $display("FAIL scan32_restart cyc %0d: xch=%0d wrap=%0d expected xch=%0d wrap=0", i, a_xch, a_wrap, i);
            else n_pass++;
        end
    endtask

    task automatic test_nonpow2();
        c_x = 20'h4_3210 + 20'h1_1111; c_en = 1; c_mode = 0; c_xs = 6;
        tick();
        n_checks++;
        if (c_xvalid !== 1'b0 || c_xout !== 4'h0 || c_xch !== 3'd6)
            $display("FAIL np2_oob: valid=%0d xout=%h xch=%0d expected 0 0 6", c_xvalid, c_xout, c_xch);
        else n_pass++;
        c_xs = 4;
        tick();
        n_checks++;
        if (c_xvalid !== 1'b1 || c_xout !== 4'h5 || c_xch !== 3'd4)
            $display("FAIL np2_last: valid=%0d xout=%h xch=%0d expected 1 5 4", c_xvalid, c_xout, c_xch);
        else n_pass++;
        c_mode = 1; c_dwell = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (c_xch !== 3'(i % 5) || c_wrap !== (i > 0 && i % 5 == 0) || act_c !== exp_c())
                $display("FAIL np2_scan cyc %0d: xch=%0d wrap=%0d expected xch=%0d wrap=%0d",
                         i, c_xch, c_wrap, i % 5, (i > 0 && i % 5 == 0));
            else n_pass++;
        end
    endtask

    task automatic test_xen_drop();
        b_en = 1; b_mode = 1; b_dwell = 3;
        for (int i = 0; i < 6; i++) tick();
        b_en = 0;
        tick();
        n_checks++;
        if (act_b !== 13'h0)
            $display("FAIL xen_drop: got %h expected 0000", act_b);
        else n_pass++;
        b_en = 1;
        tick();
        n_checks++;
        if (b_xch !== 3'd0 || b_xvalid !== 1'b1 || b_xout !== b_x[7:0] || b_wrap !== 1'b0)
            $display("FAIL xen_reenable: xch=%0d valid=%0d xout=%h expected 0 1 %h", b_xch, b_xvalid, b_xout, b_x[7:0]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) a_en = ~a_en;
            if ($urandom_range(15) == 0) a_mode = ~a_mode;
            if ($urandom_range(3) == 0) a_xs = 5'($urandom);
            if ($urandom_range(7) == 0) a_dwell = 4'($urandom_range(3));
            if ($urandom_range(15) == 0) b_en = ~b_en;
            if ($urandom_range(15) == 0) b_mode = ~b_mode;
            if ($urandom_range(3) == 0) b_xs = 3'($urandom);
            if ($urandom_range(7) == 0) b_dwell = 4'($urandom);
            if ($urandom_range(15) == 0) c_en = ~c_en;
            if ($urandom_range(15) == 0) c_mode = ~c_mode;
            if ($urandom_range(3) == 0) c_xs = 3'($urandom);
            if ($urandom_range(7) == 0) c_dwell = 4'($urandom_range(2));
            a_x = $urandom; b_x = {$urandom, $urandom}; c_x = 20'($urandom);
            tick();
            n_checks++;
            if (act_a !== exp_a()) $display("FAIL rand_a cyc %0d: got %h expected %h", i, act_a, exp_a());
            else n_pass++;
            n_checks++;
            if (act_b !== exp_b()) $display("FAIL rand_b cyc %0d: got %h expected %h", i, act_b, exp_b());
            else n_pass++;
            n_checks++;
            if (act_c !== exp_c()) $display("FAIL rand_c cyc %0d: got %h expected %h", i, act_c, exp_c());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_manual_32();
        test_manual_8();
        test_scan_8();
        test_scan_32();
        test_nonpow2();
        test_xen_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
